// File: rtl/led_matrix_pwm.sv
// Multiplexed LED matrix scanner with per-column PWM brightness,
// double-buffered frame/brightness loads and a blanking tick per column.
module led_matrix_pwm #(
    parameter int unsigned ROWS     = 8,
    parameter int unsigned COLS     = 4,
    parameter int unsigned PWM_BITS = 3,
    parameter int unsigned PRESCALE = 375,
    parameter bit          ROW_INV  = 1'b0,
    parameter bit          COL_INV  = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     load,
    input  logic [ROWS*COLS-1:0]     frame_in,
    input  logic [COLS*PWM_BITS-1:0] bright_in,
    output logic [ROWS-1:0]          rows,
    output logic [COLS-1:0]          cols,
    output logic                     frame_start,
    output logic                     pending
);

    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned FW = ROWS * COLS;
    localparam int unsigned BW = COLS * PWM_BITS;

    localparam logic [PW-1:0]       P_LAST   = PW'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] T_LAST   = '1;
    localparam logic [CW-1:0]       C_LAST   = CW'(COLS - 1);
    localparam logic [ROWS-1:0]     ROWS_OFF = {ROWS{ROW_INV}};
    localparam logic [COLS-1:0]     COLS_OFF = {COLS{COL_INV}};

    logic [PW-1:0]       p_q, p_d;
    logic [PWM_BITS-1:0] t_q, t_d;
    logic [CW-1:0]       c_q, c_d;
    logic [FW-1:0]       shadow_frame_q, shadow_frame_d;
    logic [BW-1:0]       shadow_bright_q, shadow_bright_d;
    logic [FW-1:0]       active_frame_q, active_frame_d;
    logic [BW-1:0]       active_bright_q, active_bright_d;
    logic                pending_q, pending_d;
    logic                idle_q, idle_d;
    logic [ROWS-1:0]     rows_q, rows_d;
    logic [COLS-1:0]     cols_q, cols_d;
    logic                frame_start_q, frame_start_d;

    logic                tick_en;
    logic                boundary;
    logic                swap;
    logic                lit;
    logic [ROWS-1:0]     col_rows;
    logic [PWM_BITS-1:0] col_bright;
    logic [COLS-1:0]     col_onehot;

    always_comb begin
        col_rows   = '0;
        col_bright = '0;
        col_onehot = '0;
        for (int i = 0; i < int'(COLS); i++) begin
            if (c_q == CW'(i)) begin
                col_rows      = active_frame_q[i*ROWS +: ROWS];
                col_bright    = active_bright_q[i*PWM_BITS +: PWM_BITS];
                col_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        p_d             = p_q;
        t_d             = t_q;
        c_d             = c_q;
        shadow_frame_d  = shadow_frame_q;
        shadow_bright_d = shadow_bright_q;
        active_frame_d  = active_frame_q;
        active_bright_d = active_bright_q;
        pending_d       = pending_q;
        idle_d          = ~enable;
        rows_d          = ROWS_OFF;
        cols_d          = COLS_OFF;
        frame_start_d   = 1'b0;

        tick_en  = enable && (p_q == P_LAST);
        boundary = tick_en && (t_q == T_LAST) && (c_q == C_LAST);
        // The first enabled cycle after a pause also counts as a frame start
        swap     = pending_q && (boundary || (enable && idle_q));

        if (enable) begin
            p_d = tick_en ? '0 : p_q + 1'b1;
            if (tick_en) begin
                t_d = t_q + 1'b1;
                if (t_q == T_LAST) begin
                    c_d = (c_q == C_LAST) ? '0 : c_q + 1'b1;
                end
            end
        end else begin
            p_d = '0;
            t_d = '0;
            c_d = '0;
        end

        if (swap) begin
            active_frame_d  = shadow_frame_q;
            active_bright_d = shadow_bright_q;
            pending_d       = 1'b0;
        end
        if (load) begin
            shadow_frame_d  = frame_in;
            shadow_bright_d = bright_in;
            pending_d       = 1'b1;
        end

        // Tick 0 of every slot is blank so the column switch cannot ghost
        lit = enable && (t_q != '0) && (t_q <= col_bright);
        if (lit) begin
            rows_d = col_rows ^ ROWS_OFF;
            cols_d = col_onehot ^ COLS_OFF;
        end

        frame_start_d = enable && (p_q == '0) && (t_q == '0) && (c_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q             <= '0;
            t_q             <= '0;
            c_q             <= '0;
            shadow_frame_q  <= '0;
            shadow_bright_q <= '0;
            active_frame_q  <= '0;
            active_bright_q <= '0;
            pending_q       <= 1'b0;
            idle_q          <= 1'b0;
            rows_q          <= ROWS_OFF;
            cols_q          <= COLS_OFF;
            frame_start_q   <= 1'b0;
        end else begin
            p_q             <= p_d;
            t_q             <= t_d;
            c_q             <= c_d;
            shadow_frame_q  <= shadow_frame_d;
            shadow_bright_q <= shadow_bright_d;
            active_frame_q  <= active_frame_d;
            active_bright_q <= active_bright_d;
            pending_q       <= pending_d;
            idle_q          <= idle_d;
            rows_q          <= rows_d;
            cols_q          <= cols_d;
            frame_start_q   <= frame_start_d;
        end
    end

    assign rows        = rows_q;
    assign cols        = cols_q;
    assign frame_start = frame_start_q;
    assign pending     = pending_q;

endmodule

// File: tb/tb_led_matrix_pwm.sv
// Bench for led_matrix_pwm: scoreboard of per-cycle expected outputs
// for the 8x4 instance plus a 6-column instance with flipped polarity.
module tb_led_matrix_pwm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [31:0] frame_in = '0;
    logic [11:0] bright_in = '0;
    logic [7:0]  rows;
    logic [3:0]  cols;
    logic        frame_start;
    logic        pending;

    logic        rst2 = 1'b1;
    logic        en2 = 1'b0;
    logic        ld2 = 1'b0;
    logic [47:0] fr2 = '0;
    logic [23:0] br2 = '0;
    logic [7:0]  rows2;
    logic [5:0]  cols2;
    logic        fs2;
    logic        pend2;

    led_matrix_pwm #(
        .ROWS(8), .COLS(4), .PWM_BITS(3), .PRESCALE(2),
        .ROW_INV(1'b0), .COL_INV(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load),
        .frame_in(frame_in), .bright_in(bright_in),
        .rows(rows), .cols(cols),
        .frame_start(frame_start), .pending(pending)
    );

    led_matrix_pwm #(
        .ROWS(8), .COLS(6), .PWM_BITS(4), .PRESCALE(2),
        .ROW_INV(1'b1), .COL_INV(1'b0)
    ) dut2 (
        .clk(clk), .rst(rst2), .enable(en2), .load(ld2),
        .frame_in(fr2), .bright_in(br2),
        .rows(rows2), .cols(cols2),
        .frame_start(fs2), .pending(pend2)
    );

    typedef struct packed {
        logic [7:0] rows;
        logic [3:0] cols;
        logic       fs;
        logic       pend;
    } obs_t;

    obs_t  sb_q[$];
    obs_t  o;
    int    errors = 0;
    int    checks = 0;
    string tname = "";

    // Reference state: k = cycles since scan (re)start
    int          k = 0;
    logic        idle_m = 1'b0;
    logic        pend_m = 1'b0;
    logic [31:0] sf = '0, af = '0;
    logic [11:0] sbr = '0, abr = '0;

    task automatic step(input logic r, input logic en, input logic ld,
                        input logic [31:0] fr, input logic [11:0] br);
        obs_t x;
        obs_t e;
        int   t;
        int   c;
        logic lit;
        x.rows = 8'h00;
        x.cols = 4'hF;
        x.fs   = 1'b0;
        x.pend = 1'b0;
        if (r) begin
            k = 0; idle_m = 1'b0; pend_m = 1'b0;
            sf = '0; af = '0; sbr = '0; abr = '0;
        end else if (!en) begin
            k = 0;
            idle_m = 1'b1;
            if (ld) begin
                sf = fr; sbr = br; pend_m = 1'b1;
            end
            x.pend = pend_m;
        end else begin
            t = (k / 2) % 8;
            c = (k / 16) % 4;
            lit = (t != 0) && (t <= int'(abr[c*3 +: 3]));
            if (lit) begin
                x.rows = af[c*8 +: 8];
                x.cols = ~(4'b0001 << c);
            end
            x.fs = (k % 64 == 0);
            if (pend_m && ((k % 64 == 63) || idle_m)) begin
                af = sf; abr = sbr; pend_m = 1'b0;
            end
            if (ld) begin
                sf = fr; sbr = br; pend_m = 1'b1;
            end
            idle_m = 1'b0;
            k++;
            x.pend = pend_m;
        end
        sb_q.push_back(x);
        rst = r; enable = en; load = ld; frame_in = fr; bright_in = br;
        @(negedge clk);
        o.rows = rows;
        o.cols = cols;
        o.fs   = frame_start;
        o.pend = pending;
        e = sb_q.pop_front();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL %s sb k=%0d: got rows=%h cols=%h fs=%b pend=%b, want rows=%h cols=%h fs=%b pend=%b",
                     tname, k, o.rows, o.cols, o.fs, o.pend,
                     e.rows, e.cols, e.fs, e.pend);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, '0, '0);
    endtask

    task automatic test_reset();
        int fs_n = 0;
        int lit_n = 0;
        tname = "reset";
        repeat (3) step(1'b1, 1'b1, 1'b0, '0, '0);
        checks++;
        if (rows !== 8'h00 || cols !== 4'hF || frame_start !== 1'b0 || pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got rows=%h cols=%h fs=%b pend=%b, want 00 F 0 0",
                     rows, cols, frame_start, pending);
        end
        for (int i = 0; i < 130; i++) begin
            step(1'b0, 1'b1, 1'b0, '0, '0);
            if (o.fs) fs_n++;
            if (o.rows !== 8'h00 || o.cols !== 4'hF) lit_n++;
        end
        checks++;
        if (fs_n != 3) begin
            errors++;
            $display("FAIL reset_fs_count: got %0d want 3", fs_n);
        end
        checks++;
        if (lit_n != 0) begin
            errors++;
            $display("FAIL reset_dark: got %0d lit cycles want 0", lit_n);
        end
    endtask

    task automatic test_load_frame();
        int n = 0;
        bit found = 0;
        int c0 = 0;
        int c3 = 0;
        tname = "load";
        step(1'b0, 1'b1, 1'b1, 32'hA500_00FF, 12'hFFF);
        checks++;
        if (o.pend !== 1'b1) begin
            errors++;
            $display("FAIL load_pending: got %b want 1", o.pend);
        end
        while (!found && n < 200) begin
            run(1);
            n++;
            if (o.fs && !o.pend) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL load_boundary: got timeout want frame_start");
        end
        for (int i = 0; i < 63; i++) begin
            run(1);
            if (o.cols == 4'b1110 && o.rows == 8'hFF) c0++;
            if (o.cols == 4'b0111 && o.rows == 8'hA5) c3++;
        end
        checks++;
        if (c0 != 14) begin
            errors++;
            $display("FAIL load_col0: got %0d want 14", c0);
        end
        checks++;
        if (c3 != 14) begin
            errors++;
            $display("FAIL load_col3: got %0d want 14", c3);
        end
        checks++;
        if (o.pend !== 1'b0) begin
            errors++;
            $display("FAIL load_pend_clear: got %b want 0", o.pend);
        end
    endtask

    task automatic test_brightness();
        int n = 0;
        bit found = 0;
        int cnt [4];
        int want [4];
        want = '{14, 8, 2, 0};
        cnt = '{0, 0, 0, 0};
        tname = "bright";
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 12'h067);
        while (!found && n < 200) begin
            run(1);
            n++;
            if (o.fs && !o.pend) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL bright_boundary: got timeout want frame_start");
        end
        for (int i = 0; i < 63; i++) begin
            run(1);
            for (int j = 0; j < 4; j++)
                if (o.cols == ~(4'b0001 << j)) cnt[j]++;
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (cnt[j] != want[j]) begin
                errors++;
                $display("FAIL bright_col%0d: got %0d want %0d", j, cnt[j], want[j]);
            end
        end
    endtask

    task automatic test_boundary_load();
        int a0 = 0;
        int b0 = 0;
        int p1 = 0;
        int p2 = 0;
        tname = "bnd_load";
        if (k % 64 == 63) run(1);
        step(1'b0, 1'b1, 1'b1, 32'h1122_3344, 12'hFFF);
        while (k % 64 != 63) run(1);
        step(1'b0, 1'b1, 1'b1, 32'h5566_7788, 12'hFFF);
        checks++;
        if (o.pend !== 1'b1) begin
            errors++;
            $display("FAIL bnd_pend_kept: got %b want 1", o.pend);
        end
        for (int i = 0; i < 64; i++) begin
            run(1);
            if (o.cols == 4'b1110 && o.rows == 8'h44) a0++;
            if (o.pend) p1++;
        end
        for (int i = 0; i < 64; i++) begin
            run(1);
            if (o.cols == 4'b1110 && o.rows == 8'h88) b0++;
            if (o.pend) p2++;
        end
        checks++;
        if (a0 != 14) begin
            errors++;
            $display("FAIL bnd_frameA: got %0d want 14", a0);
        end
        checks++;
        if (b0 != 14) begin
            errors++;
            $display("FAIL bnd_frameB: got %0d want 14", b0);
        end
        checks++;
        if (p1 != 63 || p2 != 0) begin
            errors++;
            $display("FAIL bnd_pending: got %0d/%0d want 63/0", p1, p2);
        end
    endtask

    task automatic test_enable();
        tname = "enable";
        run(1);
        while (k % 64 != 40) run(1);
        checks++;
        if (o.cols !== 4'b1011 || o.rows !== 8'h66) begin
            errors++;
            $display("FAIL en_midslot: got rows=%h cols=%h want 66 1011", o.rows, o.cols);
        end
        step(1'b0, 1'b0, 1'b0, '0, '0);
        checks++;
        if (o.cols !== 4'hF || o.rows !== 8'h00 || o.fs !== 1'b0) begin
            errors++;
            $display("FAIL en_off: got rows=%h cols=%h fs=%b want 00 F 0", o.rows, o.cols, o.fs);
        end
        repeat (3) step(1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 12'hFFF);
        checks++;
        if (o.pend !== 1'b1 || o.cols !== 4'hF) begin
            errors++;
            $display("FAIL en_load_idle: got pend=%b cols=%h want 1 F", o.pend, o.cols);
        end
        repeat (3) step(1'b0, 1'b0, 1'b0, '0, '0);
        run(1);
        checks++;
        if (o.fs !== 1'b1 || o.pend !== 1'b0) begin
            errors++;
            $display("FAIL en_resume: got fs=%b pend=%b want 1 0", o.fs, o.pend);
        end
        run(2);
        checks++;
        if (o.cols !== 4'b1110 || o.rows !== 8'hEF) begin
            errors++;
            $display("FAIL en_first_lit: got rows=%h cols=%h want EF 1110", o.rows, o.cols);
        end
    endtask

    task automatic test_params();
        int n = 0;
        bit found = 0;
        int bad = 0;
        int idx;
        int cnt [6];
        int first [6];
        for (int j = 0; j < 6; j++) begin
            cnt[j] = 0;
            first[j] = -1;
        end
        rst2 = 1'b1; en2 = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (rows2 !== 8'hFF || cols2 !== 6'h00 || fs2 !== 1'b0 || pend2 !== 1'b0) begin
            errors++;
            $display("FAIL p6_idle: got rows=%h cols=%h want FF 00", rows2, cols2);
        end
        rst2 = 1'b0; ld2 = 1'b1;
        fr2 = 48'h06_05_04_03_02_01;
        br2 = 24'hFF_FFFF;
        @(negedge clk);
        ld2 = 1'b0;
        checks++;
        if (pend2 !== 1'b1) begin
            errors++;
            $display("FAIL p6_pending: got %b want 1", pend2);
        end
        while (!found && n < 500) begin
            @(negedge clk);
            n++;
            if (fs2 && !pend2) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL p6_boundary: got timeout want frame_start");
        end
        for (int i = 0; i < 192; i++) begin
            if (i > 0) @(negedge clk);
            if (cols2 != 6'h00) begin
                idx = -1;
                for (int j = 0; j < 6; j++) if (cols2 == (6'b1 << j)) idx = j;
                if (idx < 0) begin
                    bad++;
                end else begin
                    cnt[idx]++;
                    if (first[idx] < 0) first[idx] = i;
                    if (rows2 != ~8'(idx + 1)) bad++;
                end
            end else if (rows2 != 8'hFF) begin
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL p6_drive: got %0d bad cycles want 0", bad);
        end
        for (int j = 0; j < 6; j++) begin
            checks++;
            if (cnt[j] != 30 || first[j] != 2 + 32 * j) begin
                errors++;
                $display("FAIL p6_col%0d: got %0d lit from %0d want 30 from %0d",
                         j, cnt[j], first[j], 2 + 32 * j);
            end
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_frame();
        test_brightness();
        test_boundary_load();
        test_enable();
        test_params();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
